// File: rtl/soc_io_pkg.sv
// Shared constants and helpers for the DE1-SoC I/O conditioning path.
package soc_io_pkg;

  localparam int N_BTN_DEF = 4;
  localparam int N_SW_DEF  = 3;
  localparam int CLK_HZ    = 50_000_000;

  // Convert a debounce interval in milliseconds into clock cycles.
  function automatic int debounce_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: two-flop synchroniser followed by a bounded
// stability counter. The output only adopts a new level after the
// synchronised input has differed from it for DEBOUNCE_CYCLES samples.
// The rise output flags the edge on which the output will go 0 -> 1.
module debounce_bit
  import soc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = debounce_cycles(20)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The count has completed and the differing level is taken this edge.
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Stability counter: cleared on agreement or acceptance, never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt    <= '0;
    end else if (accept) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  assign dout = stable;
  assign rise = accept & sync2;

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw KEY and SW pins for the button/switch PIO ports.
// Buttons are optionally inverted so pressed reads as 1, then every bit
// is synchronised and debounced independently.
// Optional feature macro: IO_COND_PRESS_PULSE_EN adds btn_press_pulse,
// a registered one-cycle strobe coinciding with each btn_clean rise.
module io_input_conditioner
  import soc_io_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int N_SW            = N_SW_DEF,
  parameter int DEBOUNCE_CYCLES = debounce_cycles(20),
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_SW-1:0]  sw_clean
`ifdef IO_COND_PRESS_PULSE_EN
  ,
  output logic [N_BTN-1:0] btn_press_pulse
`endif
);

  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] btn_rise;
  logic [N_SW-1:0]  sw_rise;
  logic             unused_sw_rise;

  // Normalise button polarity so that pressed is 1 before synchronising.
  assign btn_lvl = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Switches never generate press strobes.
  assign unused_sw_rise = ^sw_rise;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk_clk),
      .rst (reset_reset),
      .din (btn_lvl[i]),
      .dout(btn_clean[i]),
      .rise(btn_rise[i])
    );
  end

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk_clk),
      .rst (reset_reset),
      .din (sw_raw[j]),
      .dout(sw_clean[j]),
      .rise(sw_rise[j])
    );
  end

`ifdef IO_COND_PRESS_PULSE_EN
  // Register the rise indication so the strobe lands with btn_clean's rise.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      btn_press_pulse <= '0;
    end else begin
      btn_press_pulse <= btn_rise;
    end
  end
`else
  logic unused_btn_rise;
  assign unused_btn_rise = ^btn_rise;
`endif

endmodule
